wb_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the internal 8-bit Wishbone-style register bus.
- Master 0 is the parallel external bus bridge. Master 1 is the UART command bridge on the LPC TXD1/RXD1 link.
- The slave side drives the existing CHx/CLKx address decode and DAT/ACK mux.
- Grants one complete cycle at a time, uses round-robin on ties, and aborts with an error when a slave never acknowledges.

---
 rtl/wb_arbiter_if.sv | 53 +++++
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two register-bus masters, the arbiter and the slave
// decode. The arbiter connects via the master modport; the masters and the
// slave-side mux connect via the slave modport.
interface wb_arbiter_if #(
  parameter int ADR_W = 8,
  parameter int DAT_W = 8
);
  // Handshake: a master raises mX_stb_i with stable we/adr/dat and holds it
  // until mX_ack_o or mX_err_o is high for one cycle; the slave answers
  // s_stb_o with s_ack_i (and s_dat_i on reads) in the same cycle it is ready.
  logic             m0_stb_i;
  logic             m0_we_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic [DAT_W-1:0] m0_dat_o;
  logic             m0_ack_o;
  logic             m0_err_o;
  logic             m1_stb_i;
  logic             m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic [DAT_W-1:0] m1_dat_o;
  logic             m1_ack_o;
  logic             m1_err_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [DAT_W-1:0] s_dat_o;
  logic [DAT_W-1:0] s_dat_i;
  logic             s_ack_i;
  logic [1:0]       grant_o;
  logic             busy_o;

  modport master (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  s_dat_i, s_ack_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output grant_o, busy_o
  );

  modport slave (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output s_dat_i, s_ack_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter for the 8-bit register bus. One complete
// cycle is granted at a time; a cycle the slave never acknowledges is
// aborted with a one-cycle error to its owner. busy_o exposes the FSM state.
module wb_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int ADR_W   = 8,
  parameter int DAT_W   = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_arbiter_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADR_W-1:0] ADR_ZERO = '0;
  localparam logic [DAT_W-1:0] DAT_ZERO = '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant_q;

  logic             winner;
  logic             own_stb;
  logic             timeout_hit;
  logic             end_cycle;

  // Owner selection and cycle-termination conditions.
  always_comb begin
    winner      = (bus.m0_stb_i && bus.m1_stb_i) ? ~last : bus.m1_stb_i;
    own_stb     = owner ? bus.m1_stb_i : bus.m0_stb_i;
    timeout_hit = (state == BUSY) && (cnt == CNT_LAST) && !bus.s_ack_i;
    end_cycle   = bus.s_ack_i || timeout_hit || !own_stb;
  end

  // Grant / busy FSM; grant_o is registered so requests never reach it combinationally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      grant_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_stb_i || bus.m1_stb_i) begin
            owner   <= winner;
            last    <= winner;
            cnt     <= '0;
            grant_q <= winner ? 2'b10 : 2'b01;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (end_cycle) begin
            state   <= IDLE;
            cnt     <= '0;
            grant_q <= 2'b00;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner's request to the slave and the slave's answer back to the owner.
  always_comb begin
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_adr_o  = ADR_ZERO;
    bus.s_dat_o  = DAT_ZERO;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m0_dat_o = DAT_ZERO;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m1_dat_o = DAT_ZERO;
    if (state == BUSY) begin
      // The strobe is withdrawn in the abort cycle so the slave does not
      // complete an access the master has already been told failed.
      bus.s_stb_o = own_stb && !timeout_hit;
      if (owner) begin
        bus.s_we_o   = bus.m1_we_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_err_o = timeout_hit;
        bus.m1_dat_o = bus.s_dat_i;
      end else begin
        bus.s_we_o   = bus.m0_we_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_err_o = timeout_hit;
        bus.m0_dat_o = bus.s_dat_i;
      end
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.busy_o  = (state == BUSY);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter built with TIMEOUT=4: per-cycle vector table
// plus hand sequences for contention, and reset in the middle of a cycle.
module tb_wb_arbiter;
  logic clk;
  logic rst_i;

  wb_arbiter_if #(.ADR_W(8), .DAT_W(8)) bus ();

  wb_arbiter #(.TIMEOUT(4), .ADR_W(8), .DAT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.master)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] in_t [10];
  typedef logic [7:0] ex_t [12];
  typedef struct {
    in_t in_v;
    ex_t ex;
  } vec_t;

  vec_t tv[$];
  logic [7:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  string ex_name [12] = '{"grant", "busy", "s_stb", "s_we", "s_adr", "s_dat",
                          "m0_ack", "m0_err", "m0_dat", "m1_ack", "m1_err", "m1_dat"};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic add(input in_t i, input ex_t e);
    vec_t v;
    v.in_v = i;
    v.ex   = e;
    tv.push_back(v);
  endtask

  task automatic drive(input in_t i);
    bus.m0_stb_i = i[0][0];
    bus.m0_we_i  = i[1][0];
    bus.m0_adr_i = i[2];
    bus.m0_dat_i = i[3];
    bus.m1_stb_i = i[4][0];
    bus.m1_we_i  = i[5][0];
    bus.m1_adr_i = i[6];
    bus.m1_dat_i = i[7];
    bus.s_dat_i  = i[8];
    bus.s_ack_i  = i[9][0];
  endtask

  function automatic ex_t sample();
    ex_t a;
    a[0]  = {6'd0, bus.grant_o};
    a[1]  = {7'd0, bus.busy_o};
    a[2]  = {7'd0, bus.s_stb_o};
    a[3]  = {7'd0, bus.s_we_o};
    a[4]  = bus.s_adr_o;
    a[5]  = bus.s_dat_o;
    a[6]  = {7'd0, bus.m0_ack_o};
    a[7]  = {7'd0, bus.m0_err_o};
    a[8]  = bus.m0_dat_o;
    a[9]  = {7'd0, bus.m1_ack_o};
    a[10] = {7'd0, bus.m1_err_o};
    a[11] = bus.m1_dat_o;
    return a;
  endfunction

  initial begin
    ex_t act;
    int n0, n1;
    logic [7:0] e;

    // Reset state
    rst_i = 1'b0;
    drive('{default: 0});
    #12;
    act = sample();
    for (int k = 0; k < 12; k++) chk($sformatf("reset.%s", ex_name[k]), act[k], 8'h00);
    @(negedge clk);
    rst_i = 1'b1;

    // Simultaneous request after reset: m0 write first, then m1 read.
    add('{1, 1, 'h21, 'h5A, 1, 0, 'h90, 0, 0, 0},      '{default: 0});
    add('{1, 1, 'h21, 'h5A, 1, 0, 'h90, 0, 'hC3, 1},   '{1, 1, 1, 1, 'h21, 'h5A, 1, 0, 'hC3, 0, 0, 0});
    add('{0, 0, 0, 0, 1, 0, 'h90, 0, 'hC3, 0},         '{default: 0});
    add('{0, 0, 0, 0, 1, 0, 'h90, 0, 'h3C, 1},         '{2, 1, 1, 0, 'h90, 0, 0, 0, 0, 1, 0, 'h3C});
    add('{0, 0, 0, 0, 0, 0, 0, 0, 'h77, 0},            '{default: 0});
    // Single read of 0x13, ack two cycles after strobe.
    add('{1, 0, 'h13, 0, 0, 0, 0, 0, 0, 0},            '{default: 0});
    add('{1, 0, 'h13, 0, 0, 0, 0, 0, 'h66, 0},         '{1, 1, 1, 0, 'h13, 0, 0, 0, 'h66, 0, 0, 0});
    add('{1, 0, 'h13, 0, 0, 0, 0, 0, 'h66, 0},         '{1, 1, 1, 0, 'h13, 0, 0, 0, 'h66, 0, 0, 0});
    add('{1, 0, 'h13, 0, 0, 0, 0, 0, 'hA5, 1},         '{1, 1, 1, 0, 'h13, 0, 1, 0, 'hA5, 0, 0, 0});
    add('{0, 0, 0, 0, 0, 0, 0, 0, 'h77, 0},            '{default: 0});
    // Abandon: m0 drops its strobe before any ack.
    add('{1, 0, 'h55, 0, 0, 0, 0, 0, 0, 0},            '{default: 0});
    add('{1, 0, 'h55, 0, 0, 0, 0, 0, 0, 0},            '{1, 1, 1, 0, 'h55, 0, 0, 0, 0, 0, 0, 0});
    add('{0, 0, 'h55, 0, 0, 0, 0, 0, 0, 0},            '{1, 1, 0, 0, 'h55, 0, 0, 0, 0, 0, 0, 0});
    add('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},               '{default: 0});
    // Timeout: m1 wins the tie (m0 was last), slave never acks, err in 4th BUSY cycle.
    add('{1, 0, 'h01, 0, 1, 0, 'hEE, 0, 0, 0},         '{default: 0});
    add('{1, 0, 'h01, 0, 1, 0, 'hEE, 0, 0, 0},         '{2, 1, 1, 0, 'hEE, 0, 0, 0, 0, 0, 0, 0});
    add('{1, 0, 'h01, 0, 1, 0, 'hEE, 0, 0, 0},         '{2, 1, 1, 0, 'hEE, 0, 0, 0, 0, 0, 0, 0});
    add('{1, 0, 'h01, 0, 1, 0, 'hEE, 0, 0, 0},         '{2, 1, 1, 0, 'hEE, 0, 0, 0, 0, 0, 0, 0});
    add('{1, 0, 'h01, 0, 1, 0, 'hEE, 0, 0, 0},         '{2, 1, 0, 0, 'hEE, 0, 0, 0, 0, 0, 1, 0});
    add('{1, 0, 'h01, 0, 0, 0, 0, 0, 0, 0},            '{default: 0});
    add('{1, 0, 'h01, 0, 0, 0, 0, 0, 'h11, 1},         '{1, 1, 1, 0, 'h01, 0, 1, 0, 'h11, 0, 0, 0});
    add('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},               '{default: 0});
    // Ack in the same cycle as the timeout: ack wins.
    add('{0, 0, 0, 0, 1, 0, 'h42, 0, 0, 0},            '{default: 0});
    add('{0, 0, 0, 0, 1, 0, 'h42, 0, 0, 0},            '{2, 1, 1, 0, 'h42, 0, 0, 0, 0, 0, 0, 0});
    add('{0, 0, 0, 0, 1, 0, 'h42, 0, 0, 0},            '{2, 1, 1, 0, 'h42, 0, 0, 0, 0, 0, 0, 0});
    add('{0, 0, 0, 0, 1, 0, 'h42, 0, 0, 0},            '{2, 1, 1, 0, 'h42, 0, 0, 0, 0, 0, 0, 0});
    add('{0, 0, 0, 0, 1, 0, 'h42, 0, 'h99, 1},         '{2, 1, 1, 0, 'h42, 0, 0, 0, 0, 1, 0, 'h99});
    add('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},               '{default: 0});

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].in_v);
      #1;
      act = sample();
      for (int k = 0; k < 12; k++) chk($sformatf("v%0d.%s", i, ex_name[k]), act[k], tv[i].ex[k]);
    end

    // Continuous contention: last grant went to m1, so m0 leads and grants alternate.
    for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 8'h01 : 8'h02);
    n0 = 0;
    n1 = 0;
    for (int cyc = 0; cyc < 200 && (n0 < 4 || n1 < 4); cyc++) begin
      @(negedge clk);
      drive('{default: 0});
      bus.m0_stb_i = (n0 < 4);
      bus.m0_adr_i = 8'h40 + 8'(n0);
      bus.m1_stb_i = (n1 < 4);
      bus.m1_adr_i = 8'h80 + 8'(n1);
      #1;
      bus.s_ack_i = bus.s_stb_o;
      #1;
      if (bus.m0_ack_o || bus.m1_ack_o) begin
        if (exp_q.size() == 0) chk("rr.extra_ack", 8'h01, 8'h00);
        else begin
          e = exp_q.pop_front();
          chk("rr.grant", {6'd0, bus.grant_o}, e);
          chk("rr.ack_owner", {6'd0, bus.m1_ack_o, bus.m0_ack_o}, e);
        end
        if (bus.m0_ack_o) n0++;
        if (bus.m1_ack_o) n1++;
      end
    end
    chk("rr.m0_acks", 8'(n0), 8'd4);
    chk("rr.m1_acks", 8'(n1), 8'd4);
    chk("rr.leftover", 8'(exp_q.size()), 8'd0);
    @(negedge clk);
    drive('{default: 0});

    // Reset mid-cycle while m0 owns the bus (last=0), then a tie after release.
    @(negedge clk);
    bus.m0_stb_i = 1'b1;
    bus.m0_adr_i = 8'h30;
    @(negedge clk);
    #1;
    chk("rst.pre_s_stb", {7'd0, bus.s_stb_o}, 8'h01);
    chk("rst.pre_grant", {6'd0, bus.grant_o}, 8'h01);
    rst_i = 1'b0;
    #1;
    chk("rst.s_stb", {7'd0, bus.s_stb_o}, 8'h00);
    chk("rst.grant", {6'd0, bus.grant_o}, 8'h00);
    chk("rst.busy", {7'd0, bus.busy_o}, 8'h00);
    chk("rst.m0_ack", {7'd0, bus.m0_ack_o}, 8'h00);
    chk("rst.m0_err", {7'd0, bus.m0_err_o}, 8'h00);
    @(negedge clk);
    rst_i = 1'b1;
    bus.m1_stb_i = 1'b1;
    bus.m1_adr_i = 8'h31;
    @(negedge clk);
    #1;
    chk("rst.tie_grant", {6'd0, bus.grant_o}, 8'h01);
    chk("rst.tie_adr", bus.s_adr_o, 8'h30);
    @(negedge clk);
    drive('{default: 0});

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
